alu: RTL and testbench

- Execution unit on the consumer side of the reservation-station issue interface.
- Each cycle it accepts at most one ready integer op (opcode, two operands, ROB tag) from the RS.
- Computes the result and registers it for one cycle.
- Broadcasts {valid, value, tag} on the ALU result bus, which feeds RS/LSB wake-up and ROB write-back. No backpressure exists in either direction: every issued op completes in exactly one cycle.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_calc.sv | 54 +++++
 rtl/alu.sv | 64 ++++++
 tb/tb_alu.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths and op-code constants for the integer ALU, also used by
// the decoder and reservation station.
package alu_pkg;

    localparam int ROB_SIZE_WIDTH       = 4;
    localparam int CALC_OP_L1_NUM_WIDTH = 4;
    localparam int TAG_WIDTH            = ROB_SIZE_WIDTH + 1;

    localparam logic [TAG_WIDTH-1:0] NO_TAG = {TAG_WIDTH{1'b1}};

    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_ADD  = 4'd0;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_SLL  = 4'd1;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_SLT  = 4'd2;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_SLTU = 4'd3;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_XOR  = 4'd4;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_SRL  = 4'd5;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_OR   = 4'd6;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_AND  = 4'd7;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_EQ   = 4'd8;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_NE   = 4'd9;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_LT   = 4'd10;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_GE   = 4'd11;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_LTU  = 4'd12;
    localparam logic [CALC_OP_L1_NUM_WIDTH-1:0] CALC_GEU  = 4'd13;

    // Zero-extend a compare outcome to a full data word.
    function automatic logic [31:0] flag_to_word(input logic flag);
        return {31'd0, flag};
    endfunction

endpackage

// File: rtl/alu_calc.sv
// Purely combinational integer datapath: op code and operands to result.
module alu_calc
    import alu_pkg::*;
(
    input  logic [CALC_OP_L1_NUM_WIDTH-1:0] op_l1,
    input  logic                            op_l2,
    input  logic [31:0]                     opr1,
    input  logic [31:0]                     opr2,
    output logic [31:0]                     result
);

    logic [4:0] shamt_s;
    logic       lt_s;
    logic       ltu_s;

    assign shamt_s = opr2[4:0];
    assign lt_s    = ($signed(opr1) < $signed(opr2));
    assign ltu_s   = (opr1 < opr2);

    // Result select; L2 only matters for ADD/SUB and SRL/SRA.
    always_comb begin
        result = 32'd0;
        case (op_l1)
            CALC_ADD: begin
                if (op_l2) begin
                    result = opr1 - opr2;
                end else begin
                    result = opr1 + opr2;
                end
            end
            CALC_SLL:  result = opr1 << shamt_s;
            CALC_SLT:  result = flag_to_word(lt_s);
            CALC_SLTU: result = flag_to_word(ltu_s);
            CALC_XOR:  result = opr1 ^ opr2;
            CALC_SRL: begin
                if (op_l2) begin
                    result = $unsigned($signed(opr1) >>> shamt_s);
                end else begin
                    result = opr1 >> shamt_s;
                end
            end
            CALC_OR:   result = opr1 | opr2;
            CALC_AND:  result = opr1 & opr2;
            CALC_EQ:   result = flag_to_word(opr1 == opr2);
            CALC_NE:   result = flag_to_word(opr1 != opr2);
            CALC_LT:   result = flag_to_word(lt_s);
            CALC_GE:   result = flag_to_word(!lt_s);
            CALC_LTU:  result = flag_to_word(ltu_s);
            CALC_GEU:  result = flag_to_word(!ltu_s);
            default:   result = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// ALU execution unit: one op per cycle from the RS, result broadcast one
// cycle later on the ALU result bus with its ROB tag.
module alu
    import alu_pkg::*;
(
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            need_flush_in,
    input  logic                            rs2alu_ready,
    input  logic [CALC_OP_L1_NUM_WIDTH-1:0] rs2alu_op_L1,
    input  logic                            rs2alu_op_L2,
    input  logic [31:0]                     rs2alu_opr1,
    input  logic [31:0]                     rs2alu_opr2,
    input  logic [TAG_WIDTH-1:0]            rs2alu_dependency,
    output logic                            alu_valid,
    output logic [31:0]                     alu_value,
    output logic [TAG_WIDTH-1:0]            alu_dependency
);

    logic [31:0]          calc_result_s;
    logic                 valid_r;
    logic [31:0]          value_r;
    logic [TAG_WIDTH-1:0] dep_r;

    alu_calc u_calc (
        .op_l1  (rs2alu_op_L1),
        .op_l2  (rs2alu_op_L2),
        .opr1   (rs2alu_opr1),
        .opr2   (rs2alu_opr2),
        .result (calc_result_s)
    );

    // Result register: reset beats freeze, freeze beats flush. On an idle
    // cycle the value holds so only valid/tag signal the bubble.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_r <= 1'b0;
            value_r <= 32'd0;
            dep_r   <= NO_TAG;
        end else if (!rdy_in) begin
            valid_r <= valid_r;
            value_r <= value_r;
            dep_r   <= dep_r;
        end else if (need_flush_in) begin
            valid_r <= 1'b0;
            value_r <= value_r;
            dep_r   <= NO_TAG;
        end else if (rs2alu_ready) begin
            valid_r <= 1'b1;
            value_r <= calc_result_s;
            dep_r   <= rs2alu_dependency;
        end else begin
            valid_r <= 1'b0;
            value_r <= value_r;
            dep_r   <= NO_TAG;
        end
    end

    assign alu_valid      = valid_r;
    assign alu_value      = value_r;
    assign alu_dependency = dep_r;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the alu execution unit.
module tb_alu;
    import alu_pkg::*;

    logic                            clk_in = 1'b0;
    logic                            rst_in;
    logic                            rdy_in;
    logic                            need_flush_in;
    logic                            rs2alu_ready;
    logic [CALC_OP_L1_NUM_WIDTH-1:0] rs2alu_op_L1;
    logic                            rs2alu_op_L2;
    logic [31:0]                     rs2alu_opr1;
    logic [31:0]                     rs2alu_opr2;
    logic [TAG_WIDTH-1:0]            rs2alu_dependency;
    logic                            alu_valid;
    logic [31:0]                     alu_value;
    logic [TAG_WIDTH-1:0]            alu_dependency;

    int n_cmp = 0;
    int n_bad = 0;

    alu dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .need_flush_in     (need_flush_in),
        .rs2alu_ready      (rs2alu_ready),
        .rs2alu_op_L1      (rs2alu_op_L1),
        .rs2alu_op_L2      (rs2alu_op_L2),
        .rs2alu_opr1       (rs2alu_opr1),
        .rs2alu_opr2       (rs2alu_opr2),
        .rs2alu_dependency (rs2alu_dependency),
        .alu_valid         (alu_valid),
        .alu_value         (alu_value),
        .alu_dependency    (alu_dependency)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_out(input string name, input logic v, input logic [31:0] val,
                             input logic [4:0] tag);
        check({name, ".valid"}, {31'd0, alu_valid}, {31'd0, v});
        check({name, ".value"}, alu_value, val);
        check({name, ".tag"}, {27'd0, alu_dependency}, {27'd0, tag});
    endtask

    task automatic check_idle(input string name);
        check({name, ".valid"}, {31'd0, alu_valid}, 32'd0);
        check({name, ".tag"}, {27'd0, alu_dependency}, 32'h0000_001F);
    endtask

    // Drive one cycle of inputs, then sample at the following negedge.
    task automatic step(input logic rdy, input logic [3:0] op, input logic l2,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        rdy_in            = 1'b1;
        rs2alu_ready      = rdy;
        rs2alu_op_L1      = op;
        rs2alu_op_L2      = l2;
        rs2alu_opr1       = a;
        rs2alu_opr2       = b;
        rs2alu_dependency = tag;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; need_flush_in = 1'b0; rs2alu_ready = 1'b0;
        rs2alu_op_L1 = 4'd0; rs2alu_op_L2 = 1'b0; rs2alu_opr1 = 32'd0;
        rs2alu_opr2 = 32'd0; rs2alu_dependency = 5'd0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check_out("reset", 1'b0, 32'd0, 5'h1F);
        rst_in = 1'b0;
        step(1'b0, 4'd0, 1'b0, 32'd9, 32'd9, 5'd1);
        check_out("idle", 1'b0, 32'd0, 5'h1F);

        step(1'b1, 4'd0, 1'b0, 32'd5, 32'd7, 5'd3);
        check_out("add", 1'b1, 32'd12, 5'd3);
        step(1'b1, 4'd0, 1'b1, 32'd5, 32'd7, 5'd4);
        check_out("sub", 1'b1, 32'hFFFF_FFFE, 5'd4);
        step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        check_out("bubble", 1'b0, 32'hFFFF_FFFE, 5'h1F);

        step(1'b1, 4'd5, 1'b1, 32'h8000_0000, 32'h0000_0021, 5'd2);
        check_out("sra", 1'b1, 32'hC000_0000, 5'd2);
        step(1'b1, 4'd5, 1'b0, 32'h8000_0000, 32'h0000_0021, 5'd2);
        check("srl", alu_value, 32'h4000_0000);
        step(1'b1, 4'd1, 1'b0, 32'd1, 32'h0000_0024, 5'd2);
        check("sll", alu_value, 32'd16);
        step(1'b1, 4'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd2);
        check("slt", alu_value, 32'd1);
        step(1'b1, 4'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd2);
        check("sltu", alu_value, 32'd0);
        step(1'b1, 4'd4, 1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 5'd2);
        check("xor_l2", alu_value, 32'h0000_FF00);
        step(1'b1, 4'd7, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 5'd2);
        check("and", alu_value, 32'h0000_00F0);

        step(1'b1, 4'd8, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd8);
        check("eq", alu_value, 32'd0);
        step(1'b1, 4'd9, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd9);
        check("ne", alu_value, 32'd1);
        step(1'b1, 4'd10, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd10);
        check("lt", alu_value, 32'd1);
        step(1'b1, 4'd11, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd11);
        check("ge", alu_value, 32'd0);
        step(1'b1, 4'd12, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd12);
        check("ltu", alu_value, 32'd0);
        step(1'b1, 4'd13, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd13);
        check_out("geu", 1'b1, 32'd1, 5'd13);
        step(1'b1, 4'd14, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd14);
        check_out("reserved", 1'b1, 32'd0, 5'd14);

        need_flush_in = 1'b1;
        step(1'b1, 4'd0, 1'b0, 32'd3, 32'd4, 5'd5);
        check_idle("flush");
        need_flush_in = 1'b0;
        step(1'b1, 4'd6, 1'b0, 32'h0000_000A, 32'h0000_0005, 5'd7);
        check_out("post_flush", 1'b1, 32'h0000_000F, 5'd7);

        step(1'b1, 4'd0, 1'b0, 32'd1, 32'd1, 5'd6);
        check_out("pre_freeze", 1'b1, 32'd2, 5'd6);
        for (int i = 0; i < 3; i++) begin
            rdy_in            = 1'b0;
            rs2alu_ready      = i[0];
            rs2alu_op_L1      = 4'd4;
            rs2alu_opr1       = 32'h1234_5678 + i;
            rs2alu_dependency = 5'd9;
            need_flush_in     = ~i[0];
            @(posedge clk_in);
            @(negedge clk_in);
            check_out("freeze", 1'b1, 32'd2, 5'd6);
        end
        need_flush_in = 1'b0;
        rst_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check_out("freeze_reset", 1'b0, 32'd0, 5'h1F);
        rst_in = 1'b0;
        step(1'b1, 4'd0, 1'b1, 32'd10, 32'd3, 5'd1);
        check_out("after_reset", 1'b1, 32'd7, 5'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
